// File: rtl/snake_direction_ctrl_if.sv
// Button/run inputs and committed-direction outputs of the snake direction controller.
// The master side is whoever drives the buttons; the controller is the slave.
interface snake_direction_ctrl_if;
  logic       run;
  logic       btn_up;
  logic       btn_right;
  logic       btn_down;
  logic       btn_left;
  logic [3:0] direction;
  logic       move_tick;

  modport master (
    output run, btn_up, btn_right, btn_down, btn_left,
    input  direction, move_tick
  );

  modport slave (
    input  run, btn_up, btn_right, btn_down, btn_left,
    output direction, move_tick
  );
endinterface

// File: rtl/snake_direction_ctrl.sv
// Debounces four push-buttons, arbitrates one direction request per move and
// emits a paced move_tick with the committed direction, refusing 180-degree turns.
module snake_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 10_000_000
) (
  input logic                   clk,
  input logic                   rst,
  snake_direction_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_CYCLES);

  localparam logic [3:0] DIR_UP    = 4'd0;
  localparam logic [3:0] DIR_RIGHT = 4'd4;
  localparam logic [3:0] DIR_DOWN  = 4'd8;
  localparam logic [3:0] DIR_LEFT  = 4'd2;

  // Bit order doubles as arbitration priority: index 0 wins.
  logic [3:0] btn_raw;
  logic [3:0] press;
  assign btn_raw = {bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             db_reg;
      logic             db_prev_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          db_reg      <= 1'b0;
          db_prev_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          db_prev_reg <= db_reg;
          if (sync2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign press[gi] = db_reg & ~db_prev_reg;
    end
  endgenerate

  function automatic logic is_reverse(input logic [3:0] a, input logic [3:0] b);
    return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP))    ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

  logic [3:0]        direction_reg;
  logic [3:0]        pending_reg;
  logic              move_tick_reg;
  logic [TICK_W-1:0] tick_cnt_reg;

  logic       win_valid;
  logic [3:0] win_dir;
  logic       accept;
  logic       wrap;

  always_comb begin
    win_valid = 1'b1;
    win_dir   = DIR_RIGHT;
    if (press[0])      win_dir = DIR_UP;
    else if (press[1]) win_dir = DIR_RIGHT;
    else if (press[2]) win_dir = DIR_DOWN;
    else if (press[3]) win_dir = DIR_LEFT;
    else               win_valid = 1'b0;
  end

  // Reversal is judged against the committed direction so two quick turns cannot fold back.
  assign accept = win_valid && !is_reverse(win_dir, direction_reg);
  assign wrap   = bus.run && (tick_cnt_reg == TICK_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      direction_reg <= DIR_RIGHT;
      pending_reg   <= DIR_RIGHT;
      move_tick_reg <= 1'b0;
      tick_cnt_reg  <= '0;
    end else begin
      move_tick_reg <= wrap;
      if (wrap) direction_reg <= pending_reg;
      if (accept) pending_reg <= win_dir;
      if (bus.run) tick_cnt_reg <= wrap ? '0 : tick_cnt_reg + TICK_W'(1);
    end
  end

  assign bus.direction = direction_reg;
  assign bus.move_tick = move_tick_reg;
endmodule
